pipeline_scoreboard: RTL and testbench
======================================

PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  ID_LENGTH, 3, register-id width (register file holds 2**ID_LENGTH registers)
  STAGES, 3, number of tracked in-flight slots after decode (slot 1 = EX, 2 = MEM, 3 = WB; range 2..7)
  CNT_LENGTH, 16, width of the stall counter
REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  id_valid  in  1  decode stage holds a valid instruction
  id_src1, id_src2  in  ID_LENGTH  source register ids
  id_src1_used, id_src2_used  in  1  the source is actually read
  id_dst  in  ID_LENGTH  destination register id
  id_dst_wr  in  1  the instruction writes id_dst
  id_is_load  in  1  the result is ready only at the end of MEM
  flush  in  1  squash the decode instruction (taken branch, jump or return)
  stall  out  1  hold the fetch and decode stages
  issue  out  1  decode instruction enters slot 1 this cycle
  fwd_sel1, fwd_sel2  out  3  operand source: 0 = register file, k = slot k
  in_flight  out  3  count of valid slots
  stall_cycles  out  CNT_LENGTH  saturating count of stall cycles

Function
REQ-003 Each slot SHALL hold {valid, dst, wr, is_load}.
REQ-004 On every clk edge, slot k+1 SHALL take slot k, and slot 1 SHALL take the decode fields when issue=1, otherwise a bubble (valid=0).
REQ-005 The contents of slot STAGES SHALL be discarded after one cycle.
REQ-006 A source SHALL match slot k when the source is used, id_valid=1, slot k is valid with wr=1, and slot k dst equals the source id.
REQ-007 The slot with the smallest matching k SHALL win.
REQ-008 The WB slot SHALL count as a hazard, because the register file write lands at the clock edge and is not written through.
REQ-009 stall SHALL equal id_valid AND NOT flush AND a hazard on either source (hazard is defined in Configuration).
REQ-010 issue SHALL equal id_valid AND NOT stall AND NOT flush, and SHALL be combinational with zero latency.
REQ-011 When flush and a hazard occur together, flush SHALL win: stall=0, issue=0, and a bubble enters slot 1.
REQ-012 in_flight SHALL equal the number of valid slots, updated every cycle.
REQ-013 stall_cycles SHALL increment on each cycle with stall=1 and SHALL hold at 2**CNT_LENGTH-1 without wrapping.
REQ-014 fwd_selN SHALL be 0 whenever the source is not used or id_valid=0.

Reset
REQ-015 A synchronous rst=1 SHALL clear all slot valid bits and stall_cycles to 0 at the next edge, which gives stall=0, issue=0, fwd_sel1=fwd_sel2=0 and in_flight=0.
REQ-016 rst SHALL override issue and flush; an instruction offered during rst SHALL NOT enter slot 1.

Configuration
REQ-017 With PIPE_FORWARD_EN defined:
  - hazard SHALL mean the winning match is slot 1 with is_load=1 (exactly one load-use stall);
  - otherwise fwd_selN SHALL be the winning slot index, or 0 when there is no match.
REQ-018 Without PIPE_FORWARD_EN:
  - hazard SHALL mean any match in any slot;
  - fwd_sel1 and fwd_sel2 SHALL be tied to 0.

Structure
REQ-019 A shared package pipe_pkg SHALL hold:
  - typedef slot_t (the struct of REQ-003);
  - constant FWD_FROM_RF = 0;
  - the stage-index constants SLOT_EX = 1, SLOT_MEM = 2, SLOT_WB = 3.
REQ-020 A combinational sub-module hazard_match SHALL be instantiated once per source, taking the slot array and one source and returning {hit, slot index, load-hit}.

Verification (STAGES=3)
REQ-021 Reset: hold rst=1 for 2 cycles with id_valid=1 -> stall=0, issue=0, in_flight=0, stall_cycles=0.
REQ-022 Back-to-back: issue dst=R2, then src1=R2 on the next cycle:
  - with PIPE_FORWARD_EN -> stall=0, fwd_sel1=1;
  - without it -> stall=1 for 3 cycles, then issue=1.
REQ-023 Load-use: issue a load with dst=R5, then src2=R5 -> stall=1 for 1 cycle, then issue=1 with fwd_sel2=2.
REQ-024 Youngest wins: R3 written by the instructions in slots 2 and 1, then src1=R3 -> fwd_sel1=1.
REQ-025 Flush during a stall: load R4, then src1=R4 with flush=1 -> stall=0, issue=0; next cycle in_flight=1 (bubble in slot 1).
REQ-026 Saturation: with CNT_LENGTH=4, hold a hazard for 20 cycles -> stall_cycles=15 and held.

Source files
------------

// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types and constants for the pipeline scoreboard.
// Slot records are sized for register ids up to ID_MAX bits.
package pipe_pkg;

    localparam int ID_MAX = 8;

    localparam logic [2:0] FWD_FROM_RF = 3'd0;
    localparam logic [2:0] SLOT_EX     = 3'd1;
    localparam logic [2:0] SLOT_MEM    = 3'd2;
    localparam logic [2:0] SLOT_WB     = 3'd3;

    typedef struct packed {
        logic              valid;
        logic [ID_MAX-1:0] dst;
        logic              wr;
        logic              is_load;
    } slot_t;

endpackage

// File: rtl/pipeline_scoreboard_hazard_match.sv
// Finds the youngest in-flight slot that writes a given source register.
// Purely combinational; one instance per decode source operand.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int ID_LENGTH = 3,
    parameter int STAGES    = 3
) (
    input  slot_t [STAGES:1]      slots_i,
    input  logic [ID_LENGTH-1:0]  src_i,
    input  logic                  used_i,
    input  logic                  valid_i,
    output logic                  hit_o,
    output logic [2:0]            idx_o,
    output logic                  load_o
);

    logic [ID_MAX-1:0] src_ext;

    assign src_ext = ID_MAX'(src_i);

    // Scan oldest to youngest so the smallest matching slot index wins.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = FWD_FROM_RF;
        load_o = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (used_i && valid_i && slots_i[k].valid &&
                slots_i[k].wr && slots_i[k].dst == src_ext) begin
                hit_o  = 1'b1;
                idx_o  = 3'(k);
                load_o = slots_i[k].is_load;
            end
        end
    end

endmodule

// File: rtl/pipeline_scoreboard.sv
// In-order pipeline scoreboard: tracks writers after decode, stalls on hazards.
// Define PIPE_FORWARD_EN to forward from EX/MEM/WB and stall only on load-use.
module pipeline_scoreboard
    import pipe_pkg::*;
#(
    parameter int ID_LENGTH  = 3,
    parameter int STAGES     = 3,
    parameter int CNT_LENGTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [ID_LENGTH-1:0]  id_src1,
    input  logic [ID_LENGTH-1:0]  id_src2,
    input  logic                  id_src1_used,
    input  logic                  id_src2_used,
    input  logic [ID_LENGTH-1:0]  id_dst,
    input  logic                  id_dst_wr,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic                  issue,
    output logic [2:0]            fwd_sel1,
    output logic [2:0]            fwd_sel2,
    output logic [2:0]            in_flight,
    output logic [CNT_LENGTH-1:0] stall_cycles
);

    slot_t [STAGES:1]      slots_q, slots_d;
    logic [CNT_LENGTH-1:0] stall_cnt_q, stall_cnt_d;

    logic       hit1, hit2, load1, load2, haz1, haz2;
    logic [2:0] idx1, idx2;

    hazard_match #(.ID_LENGTH(ID_LENGTH), .STAGES(STAGES)) u_match1 (
        .slots_i (slots_q),
        .src_i   (id_src1),
        .used_i  (id_src1_used),
        .valid_i (id_valid),
        .hit_o   (hit1),
        .idx_o   (idx1),
        .load_o  (load1)
    );

    hazard_match #(.ID_LENGTH(ID_LENGTH), .STAGES(STAGES)) u_match2 (
        .slots_i (slots_q),
        .src_i   (id_src2),
        .used_i  (id_src2_used),
        .valid_i (id_valid),
        .hit_o   (hit2),
        .idx_o   (idx2),
        .load_o  (load2)
    );

`ifdef PIPE_FORWARD_EN
    assign haz1     = hit1 && idx1 == SLOT_EX && load1;
    assign haz2     = hit2 && idx2 == SLOT_EX && load2;
    assign fwd_sel1 = hit1 ? idx1 : FWD_FROM_RF;
    assign fwd_sel2 = hit2 ? idx2 : FWD_FROM_RF;
`else
    logic unused_match;
    assign unused_match = ^{idx1, idx2, load1, load2};
    assign haz1     = hit1;
    assign haz2     = hit2;
    assign fwd_sel1 = FWD_FROM_RF;
    assign fwd_sel2 = FWD_FROM_RF;
`endif

    // Flush beats a hazard; reset blocks any instruction from entering EX.
    assign stall = id_valid && !flush && (haz1 || haz2);
    assign issue = id_valid && !stall && !flush && !rst;

    assign stall_cycles = stall_cnt_q;

    // Advance the slot pipeline; a bubble enters EX unless decode issues.
    always_comb begin
        slots_d = '0;
        if (issue) begin
            slots_d[1].valid   = 1'b1;
            slots_d[1].dst     = ID_MAX'(id_dst);
            slots_d[1].wr      = id_dst_wr;
            slots_d[1].is_load = id_is_load;
        end
        for (int k = 2; k <= STAGES; k++) begin
            slots_d[k] = slots_q[k-1];
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_LENGTH'(1);
        end
    end

    // Count occupied slots.
    always_comb begin
        in_flight = 3'd0;
        for (int k = 1; k <= STAGES; k++) begin
            in_flight = in_flight + 3'(slots_q[k].valid);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            slots_q     <= slots_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed testbench for pipeline_scoreboard (STAGES=3, CNT_LENGTH=4).
// Expectations follow PIPE_FORWARD_EN when it is defined.
module tb_pipeline_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_src1, id_src2, id_dst;
    logic       id_src1_used, id_src2_used, id_dst_wr, id_is_load;
    logic       flush;
    logic       stall, issue;
    logic [2:0] fwd_sel1, fwd_sel2, in_flight;
    logic [3:0] stall_cycles;

    int checks = 0;
    int errors = 0;

`ifdef PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    pipeline_scoreboard #(
        .ID_LENGTH  (3),
        .STAGES     (3),
        .CNT_LENGTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src1_used (id_src1_used),
        .id_src2_used (id_src2_used),
        .id_dst       (id_dst),
        .id_dst_wr    (id_dst_wr),
        .id_is_load   (id_is_load),
        .flush        (flush),
        .stall        (stall),
        .issue        (issue),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .in_flight    (in_flight),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        id_valid = 0; id_src1 = 0; id_src2 = 0;
        id_src1_used = 0; id_src2_used = 0;
        id_dst = 0; id_dst_wr = 0; id_is_load = 0; flush = 0;
    endtask

    task automatic drain;
        clear_in();
        repeat (4) tick();
    endtask

    task automatic test_reset;
        clear_in();
        rst = 1; id_valid = 1; id_dst = 3'd1; id_dst_wr = 1;
        tick(); tick();
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got %0d expected 0", stall); end
        checks++; if (issue !== 1'b0) begin errors++;
            $display("FAIL reset_issue: got %0d expected 0", issue); end
        checks++; if (in_flight !== 3'd0) begin errors++;
            $display("FAIL reset_in_flight: got %0d expected 0", in_flight); end
        checks++; if (stall_cycles !== 4'd0) begin errors++;
            $display("FAIL reset_cnt: got %0d expected 0", stall_cycles); end
        rst = 0;
        clear_in();
        #1;
        checks++; if (fwd_sel1 !== 3'd0 || fwd_sel2 !== 3'd0) begin errors++;
            $display("FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_sel1, fwd_sel2); end
    endtask

    task automatic test_back_to_back;
        drain();
        id_valid = 1; id_dst = 3'd2; id_dst_wr = 1;
        #1;
        checks++; if (issue !== 1'b1) begin errors++;
            $display("FAIL b2b_first_issue: got %0d expected 1", issue); end
        tick();
        clear_in();
        id_valid = 1; id_src1 = 3'd2; id_src1_used = 1;
        #1;
        if (FWD) begin
            checks++; if (stall !== 1'b0) begin errors++;
                $display("FAIL b2b_stall: got %0d expected 0", stall); end
            checks++; if (fwd_sel1 !== 3'd1) begin errors++;
                $display("FAIL b2b_fwd1: got %0d expected 1", fwd_sel1); end
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (stall !== 1'b1) begin errors++;
                    $display("FAIL b2b_stall_c%0d: got %0d expected 1", i, stall); end
                tick();
            end
            checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
                $display("FAIL b2b_issue: got %0d/%0d expected 1/0", issue, stall); end
            checks++; if (fwd_sel1 !== 3'd0) begin errors++;
                $display("FAIL b2b_fwd1: got %0d expected 0", fwd_sel1); end
        end
    endtask

    task automatic test_load_use;
        drain();
        id_valid = 1; id_dst = 3'd5; id_dst_wr = 1; id_is_load = 1;
        tick();
        clear_in();
        id_valid = 1; id_src2 = 3'd5; id_src2_used = 1;
        #1;
        for (int i = 0; i < (FWD ? 1 : 3); i++) begin
            checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++;
                $display("FAIL lu_stall_c%0d: got %0d/%0d expected 1/0", i, stall, issue); end
            tick();
        end
        checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++;
            $display("FAIL lu_issue: got %0d/%0d expected 0/1", stall, issue); end
        checks++; if (fwd_sel2 !== (FWD ? 3'd2 : 3'd0)) begin errors++;
            $display("FAIL lu_fwd2: got %0d expected %0d", fwd_sel2, FWD ? 2 : 0); end
    endtask

    task automatic test_youngest;
        drain();
        id_valid = 1; id_dst = 3'd3; id_dst_wr = 1;
        tick();
        tick();
        clear_in();
        id_valid = 1; id_src1 = 3'd3; id_src1_used = 1;
        #1;
        checks++; if (in_flight !== 3'd2) begin errors++;
            $display("FAIL yw_in_flight: got %0d expected 2", in_flight); end
        checks++; if (fwd_sel1 !== (FWD ? 3'd1 : 3'd0)) begin errors++;
            $display("FAIL yw_fwd1: got %0d expected %0d", fwd_sel1, FWD ? 1 : 0); end
        checks++; if (stall !== !FWD) begin errors++;
            $display("FAIL yw_stall: got %0d expected %0d", stall, !FWD); end
        id_valid = 0;
        #1;
        checks++; if (fwd_sel1 !== 3'd0 || stall !== 1'b0) begin errors++;
            $display("FAIL yw_invalid: got %0d/%0d expected 0/0", fwd_sel1, stall); end
    endtask

    task automatic test_flush;
        drain();
        id_valid = 1; id_dst = 3'd4; id_dst_wr = 1; id_is_load = 1;
        tick();
        clear_in();
        id_valid = 1; id_src1 = 3'd4; id_src1_used = 1; flush = 1;
        #1;
        checks++; if (stall !== 1'b0 || issue !== 1'b0) begin errors++;
            $display("FAIL fl_outputs: got %0d/%0d expected 0/0", stall, issue); end
        tick();
        clear_in();
        #1;
        checks++; if (in_flight !== 3'd1) begin errors++;
            $display("FAIL fl_in_flight: got %0d expected 1", in_flight); end
    endtask

    task automatic test_saturation;
        clear_in();
        rst = 1;
        tick();
        rst = 0;
        id_valid = 1; id_src1 = 3'd1; id_src1_used = 1;
        id_dst = 3'd1; id_dst_wr = 1; id_is_load = 1;
        repeat (4) tick();
        checks++; if (stall_cycles !== (FWD ? 4'd2 : 4'd3)) begin errors++;
            $display("FAIL sat_early: got %0d expected %0d", stall_cycles, FWD ? 2 : 3); end
        repeat (36) tick();
        checks++; if (stall_cycles !== 4'd15) begin errors++;
            $display("FAIL sat_max: got %0d expected 15", stall_cycles); end
        repeat (10) tick();
        checks++; if (stall_cycles !== 4'd15) begin errors++;
            $display("FAIL sat_hold: got %0d expected 15", stall_cycles); end
        clear_in();
    endtask

    initial begin
        clear_in();
        rst = 1;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_youngest();
        test_flush();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
